// File: rtl/mfp_eic_dispatch_pkg.sv
// Shared constants and state encoding for the EIC dispatch scheduler.
package mfp_eic_dispatch_pkg;

  localparam int unsigned EIC_CHANNELS = 64;
  localparam int unsigned EIC_CNT_W    = 4;

  typedef enum logic [1:0] {
    EIC_D_IDLE  = 2'd0,
    EIC_D_OFFER = 2'd1,
    EIC_D_CLEAR = 2'd2,
    EIC_D_GAP   = 2'd3
  } eic_d_state_t;

endpackage

// File: rtl/mfp_eic_rr_select.sv
// Combinational selector: lowest set bit at or above ptr (round-robin mode),
// falling back to the lowest set bit overall; ptr is ignored in fixed mode.
module mfp_eic_rr_select
  import mfp_eic_dispatch_pkg::*;
#(
  parameter int unsigned CHANNELS = EIC_CHANNELS,
  parameter int unsigned IDX_W    = 6
) (
  input  logic [CHANNELS-1:0] pending,
  input  logic [IDX_W-1:0]    ptr,
  input  logic                mode,
  output logic                found,
  output logic [IDX_W-1:0]    index
);

  logic             found_m;
  logic [IDX_W-1:0] idx_m;
  logic             found_a;
  logic [IDX_W-1:0] idx_a;

  // Masked and unmasked priority encoders; scanning downward leaves the lowest hit.
  always_comb begin
    found_m = 1'b0;
    idx_m   = '0;
    found_a = 1'b0;
    idx_a   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found_a = 1'b1;
        idx_a   = IDX_W'(i);
        if (!mode || (IDX_W'(i) >= ptr)) begin
          found_m = 1'b1;
          idx_m   = IDX_W'(i);
        end
      end
    end
    found = found_a;
    index = found_m ? idx_m : idx_a;
  end

endmodule

// File: rtl/mfp_eic_dispatch.sv
// EIC interrupt dispatch: arbitrate pending flags, offer one request to the
// CPU, clear its flag after acknowledge, then hold off before re-arbitrating.
module mfp_eic_dispatch
  import mfp_eic_dispatch_pkg::*;
#(
  parameter int unsigned CHANNELS = EIC_CHANNELS,
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned HOLDOFF  = 2
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [CHANNELS-1:0] pending,
  input  logic                rr_enable,
  input  logic                cpu_ack,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic                clr_valid,
  output logic [IDX_W-1:0]    clr_index,
  output logic                spurious_ack
);

  eic_d_state_t         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [EIC_CNT_W-1:0] cnt_q, cnt_d;
  logic                 mode_q, mode_d;

  logic [7:0]           intr_d;
  logic                 clr_valid_d;
  logic [IDX_W-1:0]     clr_index_d;
  logic                 spurious_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 pre_found;
  logic [IDX_W-1:0]     pre_idx;

  // Arbitration winner in the currently selected mode.
  mfp_eic_rr_select #(.CHANNELS(CHANNELS), .IDX_W(IDX_W)) u_win (
    .pending (pending),
    .ptr     (rr_ptr_q),
    .mode    (rr_enable),
    .found   (win_found),
    .index   (win_idx)
  );

  // Lowest pending index, used for fixed-mode preemption while offering.
  mfp_eic_rr_select #(.CHANNELS(CHANNELS), .IDX_W(IDX_W)) u_pre (
    .pending (pending),
    .ptr     ('0),
    .mode    (1'b0),
    .found   (pre_found),
    .index   (pre_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    case (state_q)
      EIC_D_IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          mode_d  = rr_enable;
          state_d = EIC_D_OFFER;
        end
      end
      EIC_D_OFFER: begin
        if (cpu_ack) begin
          state_d = EIC_D_CLEAR;
        end else if (!pending[idx_q]) begin
          state_d = EIC_D_IDLE;
        end else if (!mode_q && pre_found && (pre_idx < idx_q)) begin
          idx_d = pre_idx;
        end
      end
      EIC_D_CLEAR: begin
        rr_ptr_d = (idx_q == IDX_W'(CHANNELS - 1)) ? '0 : idx_q + IDX_W'(1);
        cnt_d    = EIC_CNT_W'(HOLDOFF);
        state_d  = EIC_D_GAP;
      end
      EIC_D_GAP: begin
        if (cnt_q <= EIC_CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = EIC_D_IDLE;
        end else begin
          cnt_d = cnt_q - EIC_CNT_W'(1);
        end
      end
      default: state_d = EIC_D_IDLE;
    endcase

    intr_d      = (state_d == EIC_D_OFFER) ? (8'(idx_d) + 8'd1) : 8'd0;
    clr_valid_d = (state_d == EIC_D_CLEAR);
    clr_index_d = (state_d == EIC_D_CLEAR) ? idx_q : '0;
    spurious_d  = cpu_ack && (state_q != EIC_D_OFFER);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q       <= EIC_D_IDLE;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      EIC_Interrupt <= '0;
      EIC_Vector    <= '0;
      clr_valid     <= 1'b0;
      clr_index     <= '0;
      spurious_ack  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      EIC_Interrupt <= intr_d;
      EIC_Vector    <= intr_d[5:0];
      clr_valid     <= clr_valid_d;
      clr_index     <= clr_index_d;
      spurious_ack  <= spurious_d;
    end
  end

endmodule

// File: tb/tb_mfp_eic_dispatch.sv
// Directed bench for mfp_eic_dispatch (CHANNELS=64, HOLDOFF=2).
module tb_mfp_eic_dispatch;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic [63:0] pending;
  logic        rr_enable;
  logic        cpu_ack;
  logic [7:0]  EIC_Interrupt;
  logic [5:0]  EIC_Vector;
  logic        clr_valid;
  logic [5:0]  clr_index;
  logic        spurious_ack;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  mfp_eic_dispatch #(.CHANNELS(64), .IDX_W(6), .HOLDOFF(2)) dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .pending       (pending),
    .rr_enable     (rr_enable),
    .cpu_ack       (cpu_ack),
    .EIC_Interrupt (EIC_Interrupt),
    .EIC_Vector    (EIC_Vector),
    .clr_valid     (clr_valid),
    .clr_index     (clr_index),
    .spurious_ack  (spurious_ack)
  );

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_intr"}, 64'(EIC_Interrupt), 64'd0);
    chk({tag, "_vec"},  64'(EIC_Vector),    64'd0);
    chk({tag, "_clrv"}, 64'(clr_valid),     64'd0);
    chk({tag, "_clri"}, 64'(clr_index),     64'd0);
    chk({tag, "_spur"}, 64'(spurious_ack),  64'd0);
  endtask

  int exp_idx [4] = '{1, 63, 1, 63};
  int exp_ptr [4] = '{2, 0, 2, 0};

  initial begin
    RESETn = 1'b0; pending = '0; rr_enable = 1'b0; cpu_ack = 1'b0;
    step(); step();
    chk_idle_outputs("reset");
    chk("reset_state", 64'(dut.state_q), 64'd0);
    RESETn = 1'b1;

    // Fixed priority: bits 2 and 4 pending, channel 2 wins.
    pending = 64'h14;
    step();
    chk("fix_intr3", 64'(EIC_Interrupt), 64'd3);
    chk("fix_vec3",  64'(EIC_Vector),    64'd3);
    cpu_ack = 1'b1;
    step();
    chk("fix_clrv",  64'(clr_valid),     64'd1);
    chk("fix_clri",  64'(clr_index),     64'd2);
    chk("fix_clr_intr", 64'(EIC_Interrupt), 64'd0);
    cpu_ack = 1'b0; pending = 64'h10;
    step();
    chk("fix_clr_pulse", 64'(clr_valid), 64'd0);
    chk("fix_gap1", 64'(EIC_Interrupt), 64'd0);
    chk("fix_ptr3", 64'(dut.rr_ptr_q),  64'd3);
    step();
    chk("fix_gap2", 64'(EIC_Interrupt), 64'd0);
    step();
    chk("fix_idle", 64'(EIC_Interrupt), 64'd0);
    step();
    chk("fix_intr5", 64'(EIC_Interrupt), 64'd5);

    // Acknowledge channel 4, then a stray ack during the gap.
    cpu_ack = 1'b1;
    step();
    chk("fix_clri4", 64'(clr_index), 64'd4);
    cpu_ack = 1'b0; pending = '0;
    step();
    chk("gap_spur_pre", 64'(spurious_ack), 64'd0);
    cpu_ack = 1'b1;
    step();
    chk("gap_spur", 64'(spurious_ack), 64'd1);
    chk("gap_state", 64'(dut.state_q), 64'd3);
    chk("gap_clrv",  64'(clr_valid),   64'd0);
    cpu_ack = 1'b0;
    step();
    chk("gap_spur_end", 64'(spurious_ack), 64'd0);
    chk("gap_to_idle", 64'(dut.state_q), 64'd0);

    // Round-robin wrap between channels 1 and 63, starting from a fresh pointer.
    RESETn = 1'b0;
    step();
    RESETn = 1'b1; rr_enable = 1'b1;
    pending = (64'd1 << 1) | (64'd1 << 63);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_intr", 64'(EIC_Interrupt), 64'(exp_idx[k] + 1));
      chk("rr_vec",  64'(EIC_Vector),    64'((exp_idx[k] + 1) % 64));
      cpu_ack = 1'b1;
      step();
      cpu_ack = 1'b0;
      chk("rr_clrv", 64'(clr_valid), 64'd1);
      chk("rr_clri", 64'(clr_index), 64'(exp_idx[k]));
      step();
      chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(exp_ptr[k]));
      step();
      step();
    end
    pending = '0; rr_enable = 1'b0;
    step();

    // Withdraw: channel 5 offered, then software clears its flag.
    pending = 64'd1 << 5;
    step();
    chk("wd_intr6", 64'(EIC_Interrupt), 64'd6);
    pending = '0;
    step();
    chk("wd_intr0", 64'(EIC_Interrupt), 64'd0);
    chk("wd_clrv",  64'(clr_valid),     64'd0);
    chk("wd_state", 64'(dut.state_q),   64'd0);
    step();
    chk("wd_clrv2", 64'(clr_valid), 64'd0);

    // Fixed-mode preemption by a lower index.
    pending = 64'd1 << 10;
    step();
    chk("pre_intr11", 64'(EIC_Interrupt), 64'd11);
    pending = (64'd1 << 10) | (64'd1 << 3);
    step();
    chk("pre_intr4", 64'(EIC_Interrupt), 64'd4);
    pending = '0;
    step();
    chk("pre_withdraw", 64'(EIC_Interrupt), 64'd0);

    // Same scenario in round-robin mode: no preemption, even after mode flips.
    rr_enable = 1'b1;
    pending = 64'd1 << 10;
    step();
    chk("rrpre_intr11", 64'(EIC_Interrupt), 64'd11);
    pending = (64'd1 << 10) | (64'd1 << 3);
    step();
    chk("rrpre_hold", 64'(EIC_Interrupt), 64'd11);
    rr_enable = 1'b0;
    step();
    chk("rrpre_modeflip", 64'(EIC_Interrupt), 64'd11);

    // Ack and withdraw in the same cycle: ack wins.
    cpu_ack = 1'b1; pending = 64'd1 << 3;
    step();
    cpu_ack = 1'b0;
    chk("sim_clrv", 64'(clr_valid), 64'd1);
    chk("sim_clri", 64'(clr_index), 64'd10);
    step();
    chk("sim_ptr11", 64'(dut.rr_ptr_q), 64'd11);

    // Round-robin from pointer 11 picks 20 over 3; then reset mid-offer.
    rr_enable = 1'b1;
    pending = (64'd1 << 3) | (64'd1 << 20);
    step();
    step();
    chk("rst_pre_idle", 64'(EIC_Interrupt), 64'd0);
    step();
    chk("rst_offer21", 64'(EIC_Interrupt), 64'd21);
    RESETn = 1'b0;
    step();
    chk_idle_outputs("rst_mid");
    RESETn = 1'b1;
    step();
    chk("rst_after_ptr", 64'(dut.rr_ptr_q), 64'd0);
    chk("rst_after_intr4", 64'(EIC_Interrupt), 64'd4);
    chk("rst_after_clrv", 64'(clr_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
